accu_core_mc: RTL

- Parametrised multicycle successor to the 8-bit accumulator processor.
- Width, register count and return-stack depth are generic.
- Program memory and data memory are external, each behind a req/ack handshake, so wait-stated memories are supported.
- Adds CALL/RET with a hardware return stack, conditional jumps, HALT and fault detection; sits between the program/data memory interfaces and the system top.

---
 rtl/accu_core_mc.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/accu_core_mc.sv
// Multicycle accumulator core with a generic width, a register file, a hardware return stack and req/ack memory ports.
// Latency: FETCH+EXEC per instruction (2 cycles minimum), and LDM/STM add a MEM phase that lasts until dm_ack.
// Backpressure: ins_req and dm_req are held with stable address/data until ack. HALT/FAULT are left only by Reset.
// Optional trace outputs (retire_valid/retire_pc/retire_op) are enabled by defining ACCU_CORE_MC_TRACE_EN.
module accu_core_mc #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 6,
   parameter int NREGS       = 16,
   parameter int STACK_DEPTH = 4
) (
   input  logic              clk,
   input  logic              Reset,
   output logic              ins_req,
   output logic [ADDR_W-1:0] ins_addr,
   input  logic              ins_ack,
   input  logic [DATA_W+4:0] ins_data,
   output logic              dm_req,
   output logic              dm_we,
   output logic [DATA_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wdata,
   input  logic              dm_ack,
   input  logic [DATA_W-1:0] dm_rdata,
   output logic [DATA_W-1:0] accu,
   output logic              carry,
   output logic              halted,
   output logic              fault
`ifdef ACCU_CORE_MC_TRACE_EN
   ,
   output logic              retire_valid,
   output logic [ADDR_W-1:0] retire_pc,
   output logic [4:0]        retire_op
`endif
);

   localparam int RI_W = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam int SP_W = $clog2(STACK_DEPTH + 1);
   localparam int SI_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [SP_W-1:0]   SP_FULL = SP_W'(STACK_DEPTH);
   localparam logic [SP_W-1:0]   SP_ONE  = SP_W'(1);
   localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

   localparam logic [4:0] OP_NOP  = 5'h00;
   localparam logic [4:0] OP_LDI  = 5'h01;
   localparam logic [4:0] OP_LDR  = 5'h02;
   localparam logic [4:0] OP_STR  = 5'h03;
   localparam logic [4:0] OP_LDM  = 5'h04;
   localparam logic [4:0] OP_STM  = 5'h05;
   localparam logic [4:0] OP_ADD  = 5'h06;
   localparam logic [4:0] OP_ADDC = 5'h07;
   localparam logic [4:0] OP_SUB  = 5'h08;
   localparam logic [4:0] OP_AND  = 5'h09;
   localparam logic [4:0] OP_OR   = 5'h0A;
   localparam logic [4:0] OP_XOR  = 5'h0B;
   localparam logic [4:0] OP_JMP  = 5'h0C;
   localparam logic [4:0] OP_JZ   = 5'h0D;
   localparam logic [4:0] OP_JC   = 5'h0E;
   localparam logic [4:0] OP_CALL = 5'h0F;
   localparam logic [4:0] OP_RET  = 5'h10;
   localparam logic [4:0] OP_HALT = 5'h11;

   typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_HALT, S_FAULT} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [DATA_W-1:0] r_a;
   logic              r_c;
   logic [DATA_W+4:0] r_ir;
   logic [SP_W-1:0]   r_sp;
   logic [DATA_W-1:0] r_regs  [NREGS];
   logic [ADDR_W-1:0] r_stack [2**SI_W];

   state_t            w_state_nxt;
   logic [ADDR_W-1:0] w_pc_nxt;
   logic [DATA_W-1:0] w_a_nxt;
   logic              w_c_nxt;
   logic [DATA_W+4:0] w_ir_nxt;
   logic              w_reg_we;
   logic              w_push;
   logic              w_pop;

   logic [4:0]        w_op;
   logic [DATA_W-1:0] w_opr;
   logic [RI_W-1:0]   w_ridx;
   logic [DATA_W-1:0] w_rval;
   logic [ADDR_W-1:0] w_pc_inc;
   logic [ADDR_W-1:0] w_jmp_tgt;
   logic              w_cin;
   logic [DATA_W:0]   w_sum;
   logic [DATA_W:0]   w_diff;
   logic [SP_W-1:0]   w_sp_dec;
   logic [SI_W-1:0]   w_push_idx;
   logic [SI_W-1:0]   w_pop_idx;

   assign w_op       = r_ir[DATA_W+4:DATA_W];
   assign w_opr      = r_ir[DATA_W-1:0];
   assign w_ridx     = w_opr[RI_W-1:0];
   assign w_rval     = r_regs[w_ridx];
   assign w_pc_inc   = r_pc + PC_ONE;
   assign w_jmp_tgt  = w_opr[ADDR_W-1:0];
   assign w_cin      = (w_op == OP_ADDC) & r_c;
   assign w_sum      = {1'b0, r_a} + {1'b0, w_rval} + {{DATA_W{1'b0}}, w_cin};
   // Top bit of the widened difference is the borrow out of the MSB.
   assign w_diff     = {1'b0, r_a} - {1'b0, w_rval};
   assign w_sp_dec   = r_sp - SP_ONE;
   // Pushes only happen with sp < depth, and pops only with sp >= 1, so both indices fit in SI_W bits.
   assign w_push_idx = r_sp[SI_W-1:0];
   assign w_pop_idx  = w_sp_dec[SI_W-1:0];

   // Requests are gated by Reset so a reset cuts an open handshake in the same cycle.
   assign ins_req  = (r_state == S_FETCH) && !Reset;
   assign ins_addr = r_pc;
   assign dm_req   = (r_state == S_MEM) && !Reset;
   assign dm_we    = dm_req && (w_op == OP_STM);
   assign dm_addr  = w_opr;
   assign dm_wdata = r_a;
   assign accu     = r_a;
   assign carry    = r_c;
   assign halted   = (r_state == S_HALT) || (r_state == S_FAULT);
   assign fault    = (r_state == S_FAULT);

   // Next-state and datapath decode. Each instruction defaults to PC+1 and a return to FETCH.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_a_nxt     = r_a;
      w_c_nxt     = r_c;
      w_ir_nxt    = r_ir;
      w_reg_we    = 1'b0;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      case (r_state)
         S_FETCH: begin
            if (ins_req && ins_ack) begin
               w_ir_nxt    = ins_data;
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_FETCH;
            case (w_op)
               OP_NOP: ;
               OP_LDI:  w_a_nxt = w_opr;
               OP_LDR:  w_a_nxt = w_rval;
               OP_STR:  w_reg_we = 1'b1;
               OP_LDM, OP_STM: begin
                  w_pc_nxt    = r_pc;
                  w_state_nxt = S_MEM;
               end
               OP_ADD, OP_ADDC: {w_c_nxt, w_a_nxt} = w_sum;
               OP_SUB:  {w_c_nxt, w_a_nxt} = w_diff;
               OP_AND:  w_a_nxt = r_a & w_rval;
               OP_OR:   w_a_nxt = r_a | w_rval;
               OP_XOR:  w_a_nxt = r_a ^ w_rval;
               OP_JMP:  w_pc_nxt = w_jmp_tgt;
               OP_JZ:   if (r_a == '0) w_pc_nxt = w_jmp_tgt;
               OP_JC:   if (r_c) w_pc_nxt = w_jmp_tgt;
               OP_CALL: begin
                  if (r_sp == SP_FULL) begin
                     w_pc_nxt    = r_pc;
                     w_state_nxt = S_FAULT;
                  end else begin
                     w_push   = 1'b1;
                     w_pc_nxt = w_jmp_tgt;
                  end
               end
               OP_RET: begin
                  if (r_sp == '0) begin
                     w_pc_nxt    = r_pc;
                     w_state_nxt = S_FAULT;
                  end else begin
                     w_pop    = 1'b1;
                     w_pc_nxt = r_stack[w_pop_idx];
                  end
               end
               OP_HALT: begin
                  w_pc_nxt    = r_pc;
                  w_state_nxt = S_HALT;
               end
               default: begin
                  w_pc_nxt    = r_pc;
                  w_state_nxt = S_FAULT;
               end
            endcase
         end
         S_MEM: begin
            if (dm_ack) begin
               if (w_op == OP_LDM) w_a_nxt = dm_rdata;
               w_pc_nxt    = w_pc_inc;
               w_state_nxt = S_FETCH;
            end
         end
         S_HALT:  w_state_nxt = S_HALT;
         S_FAULT: w_state_nxt = S_FAULT;
         default: w_state_nxt = S_FAULT;
      endcase
   end

   // State, architectural registers and stack pointer, all cleared by Reset.
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_state <= S_FETCH;
         r_pc    <= '0;
         r_a     <= '0;
         r_c     <= 1'b0;
         r_ir    <= '0;
         r_sp    <= '0;
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_a     <= w_a_nxt;
         r_c     <= w_c_nxt;
         r_ir    <= w_ir_nxt;
         if (w_reg_we) r_regs[w_ridx] <= r_a;
         if (w_push)     r_sp <= r_sp + SP_ONE;
         else if (w_pop) r_sp <= w_sp_dec;
      end
   end

   // Return-stack storage. Entries above sp are never read, so they need no reset.
   always_ff @(posedge clk) begin
      if (!Reset && w_push) r_stack[w_push_idx] <= w_pc_inc;
   end

`ifdef ACCU_CORE_MC_TRACE_EN
   // Retire pulses when EXEC completes to FETCH/HALT or when a MEM access is acked. PC and IR still describe that instruction.
   assign retire_valid = !Reset &&
                         (((r_state == S_EXEC) && ((w_state_nxt == S_FETCH) || (w_state_nxt == S_HALT))) ||
                          ((r_state == S_MEM) && dm_ack));
   assign retire_pc    = r_pc;
   assign retire_op    = w_op;
`endif

endmodule
